// File: rtl/ov7670_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ov7670_capture_pkg
// Description : Shared frame geometry defaults and capture FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package ov7670_capture_pkg;

   localparam int H_PIXELS     = 640;
   localparam int V_LINES      = 480;
   localparam int FRAME_PIXELS = H_PIXELS * V_LINES;
   localparam int ADDR_W       = 19;

   localparam int STATE_W = 2;
   localparam logic [STATE_W-1:0] ST_IDLE        = 2'd0;
   localparam logic [STATE_W-1:0] ST_WAIT_VS_LOW = 2'd1;
   localparam logic [STATE_W-1:0] ST_CAPTURE     = 2'd2;

endpackage
`default_nettype wire

// File: rtl/ov7670_capture.sv
`default_nettype none
// ============================================================================
// Module      : ov7670_capture
// Description : OV7670 RGB444 byte-pair capture into a linear frame buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module ov7670_capture #(
   parameter int H_PIXELS = ov7670_capture_pkg::H_PIXELS,
   parameter int V_LINES  = ov7670_capture_pkg::V_LINES,
   parameter int ADDR_W   = ov7670_capture_pkg::ADDR_W
) (
   input  logic              pclk,
   input  logic              rst,
   input  logic              vsync,
   input  logic              href,
   input  logic [7:0]        d,
   output logic [ADDR_W-1:0] addr,
   output logic [11:0]       dout,
   output logic              we,
   output logic              frame_done,
   output logic [9:0]        line_count,
   output logic              err_line
);
   import ov7670_capture_pkg::*;

   localparam int c_FRAME_PIX = H_PIXELS * V_LINES;
   localparam int c_PIX_W     = $clog2(H_PIXELS + 2);
   localparam logic [ADDR_W-1:0]  c_LAST_ADDR = ADDR_W'(c_FRAME_PIX - 1);
   localparam logic [c_PIX_W-1:0] c_PIX_H     = c_PIX_W'(H_PIXELS);
   localparam logic [c_PIX_W-1:0] c_PIX_SAT   = c_PIX_W'(H_PIXELS + 1);

   logic               r_vs;
   logic               r_hr;
   logic [7:0]         r_d;
   logic               r_vs_prev;
   logic               r_hr_prev;
   logic [STATE_W-1:0] r_state;
   logic [STATE_W-1:0] w_next;
   logic               r_phase;
   logic [3:0]         r_red;
   logic [c_PIX_W-1:0] r_pix_cnt;
   logic               r_full;

   logic w_vs_rise;
   logic w_capture;
   logic w_clear;
   logic w_frame_end;
   logic w_pix_ev;
   logic w_line_end;

   assign w_vs_rise = r_vs & ~r_vs_prev;

   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // IDLE only leaves on vsync high so a frame already in flight is skipped
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:        if (r_vs)      w_next = ST_WAIT_VS_LOW;
         ST_WAIT_VS_LOW: if (!r_vs)     w_next = ST_CAPTURE;
         ST_CAPTURE:     if (w_vs_rise) w_next = ST_WAIT_VS_LOW;
         default:                       w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      w_capture   = 1'b0;
      w_clear     = 1'b0;
      w_frame_end = 1'b0;
      w_pix_ev    = 1'b0;
      w_line_end  = 1'b0;
      case (r_state)
         ST_WAIT_VS_LOW: w_clear = 1'b1;
         ST_CAPTURE: begin
            w_capture   = 1'b1;
            w_frame_end = w_vs_rise;
            w_pix_ev    = ~w_vs_rise & r_hr & r_phase;
            w_line_end  = ~w_vs_rise & r_hr_prev & ~r_hr;
         end
         default: ;
      endcase
   end

   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         r_vs       <= 1'b0;
         r_hr       <= 1'b0;
         r_d        <= 8'd0;
         r_vs_prev  <= 1'b0;
         r_hr_prev  <= 1'b0;
         r_phase    <= 1'b0;
         r_red      <= 4'd0;
         r_pix_cnt  <= '0;
         r_full     <= 1'b0;
         addr       <= '0;
         dout       <= 12'd0;
         we         <= 1'b0;
         frame_done <= 1'b0;
         line_count <= 10'd0;
         err_line   <= 1'b0;
      end else begin
         r_vs       <= vsync;
         r_hr       <= href;
         r_d        <= d;
         r_vs_prev  <= r_vs;
         r_hr_prev  <= r_hr;
         frame_done <= w_frame_end;
         we         <= 1'b0;

         if (w_clear) begin
            addr       <= '0;
            line_count <= 10'd0;
            err_line   <= 1'b0;
            r_pix_cnt  <= '0;
            r_phase    <= 1'b0;
            r_full     <= 1'b0;
         end else begin
            r_phase <= w_capture & r_hr & ~r_phase;

            if (w_capture && r_hr && !r_phase) begin
               r_red <= r_d[3:0];
            end

            if (w_pix_ev) begin
               if (r_pix_cnt != c_PIX_SAT) begin
                  r_pix_cnt <= r_pix_cnt + 1'b1;
               end
               if (r_full) begin
                  err_line <= 1'b1;
               end else begin
                  we   <= 1'b1;
                  dout <= {r_red, r_d[7:4], r_d[3:0]};
               end
            end

            // Address advances after each write; the last frame slot pins it
            if (we) begin
               if (addr == c_LAST_ADDR) begin
                  r_full <= 1'b1;
               end else begin
                  addr <= addr + 1'b1;
               end
            end

            if (w_line_end) begin
               if (line_count != 10'd1023) begin
                  line_count <= line_count + 10'd1;
               end
               if (r_pix_cnt != c_PIX_H) begin
                  err_line <= 1'b1;
               end
               r_pix_cnt <= '0;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ov7670_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_ov7670_capture
// Description : Directed self-checking bench for ov7670_capture (4x3 frame).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ov7670_capture;

   localparam int H = 4;
   localparam int V = 3;
   localparam int AW = 19;

   logic          pclk = 1'b0;
   logic          rst = 1'b1;
   logic          vsync = 1'b0;
   logic          href = 1'b0;
   logic [7:0]    d = 8'd0;
   logic [AW-1:0] addr;
   logic [11:0]   dout;
   logic          we;
   logic          frame_done;
   logic [9:0]    line_count;
   logic          err_line;

   int errors = 0;
   int checks = 0;
   int wr_total = 0;
   int wr_frame = 0;
   int addr_err = 0;
   int n_abc = 0;
   int fd_cnt = 0;

   ov7670_capture #(.H_PIXELS(H), .V_LINES(V), .ADDR_W(AW)) dut (
      .pclk       (pclk),
      .rst        (rst),
      .vsync      (vsync),
      .href       (href),
      .d          (d),
      .addr       (addr),
      .dout       (dout),
      .we         (we),
      .frame_done (frame_done),
      .line_count (line_count),
      .err_line   (err_line)
   );

   always #5 pclk = ~pclk;

   // Write monitor: each write in a frame must land at the next linear address
   always @(negedge pclk) begin
      if (rst) begin
         wr_frame <= 0;
      end else begin
         if (we) begin
            wr_total <= wr_total + 1;
            if (addr !== AW'(wr_frame)) addr_err <= addr_err + 1;
            if (dout === 12'hABC) n_abc <= n_abc + 1;
            wr_frame <= wr_frame + 1;
         end
         if (frame_done) begin
            fd_cnt   <= fd_cnt + 1;
            wr_frame <= 0;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic step(input logic vs, input logic hr, input logic [7:0] b);
      vsync = vs;
      href  = hr;
      d     = b;
      @(posedge pclk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 1'b0, 8'h00);
   endtask

   task automatic frame_start();
      repeat (3) step(1'b1, 1'b0, 8'h00);
      repeat (3) step(1'b0, 1'b0, 8'h00);
   endtask

   task automatic frame_end();
      repeat (3) step(1'b1, 1'b0, 8'h00);
   endtask

   task automatic send_line(input int nbytes);
      for (int i = 0; i < nbytes; i++) begin
         step(1'b0, 1'b1, (i % 2 == 1) ? 8'hBC : 8'h0A);
      end
      idle(4);
   endtask

   initial begin
      #200_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset values, then release reset in the middle of an active line
      repeat (2) step(1'b0, 1'b1, 8'h0A);
      chk("rst_addr", 32'(addr), 32'd0);
      chk("rst_dout", 32'(dout), 32'd0);
      chk("rst_we", 32'(we), 32'd0);
      chk("rst_fd", 32'(frame_done), 32'd0);
      chk("rst_lines", 32'(line_count), 32'd0);
      chk("rst_err", 32'(err_line), 32'd0);
      step(1'b0, 1'b1, 8'hBC);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) step(1'b0, 1'b1, (i % 2 == 1) ? 8'hBC : 8'h0A);
      idle(4);
      send_line(8);
      chk("startup_no_write", 32'(wr_total), 32'd0);

      // Frame A: latency pixel, short line, odd-length line
      frame_start();
      chk("wait_addr", 32'(addr), 32'd0);
      step(1'b0, 1'b1, 8'h05);
      step(1'b0, 1'b1, 8'h6F);
      chk("lat_we_early", 32'(we), 32'd0);
      step(1'b0, 1'b1, 8'h0A);
      chk("lat_we", 32'(we), 32'd1);
      chk("lat_dout", 32'(dout), 32'h56F);
      chk("lat_addr", 32'(addr), 32'd0);
      step(1'b0, 1'b1, 8'hBC);
      chk("we_pulse", 32'(we), 32'd0);
      chk("dout_hold", 32'(dout), 32'h56F);
      chk("addr_inc", 32'(addr), 32'd1);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, (i % 2 == 1) ? 8'hBC : 8'h0A);
      idle(4);
      chk("line1_count", 32'(line_count), 32'd1);
      chk("line1_err", 32'(err_line), 32'd0);
      send_line(6);
      chk("short_err", 32'(err_line), 32'd1);
      chk("short_next_addr", 32'(addr), 32'd7);
      send_line(9);
      chk("odd_writes", 32'(wr_total), 32'd11);
      chk("odd_abc", 32'(n_abc), 32'd10);
      chk("a_lines", 32'(line_count), 32'd3);
      chk("a_err_sticky", 32'(err_line), 32'd1);
      frame_end();
      chk("a_frame_done", 32'(fd_cnt), 32'd1);
      chk("wait_clr_err", 32'(err_line), 32'd0);
      chk("wait_clr_lines", 32'(line_count), 32'd0);
      chk("wait_clr_addr", 32'(addr), 32'd0);

      // Frame B: nominal full frame
      frame_start();
      repeat (V) send_line(2 * H);
      chk("nom_writes", 32'(wr_total), 32'd23);
      chk("nom_addr", 32'(addr), 32'(H * V - 1));
      chk("nom_lines", 32'(line_count), 32'd3);
      chk("nom_err", 32'(err_line), 32'd0);
      frame_end();
      chk("nom_frame_done", 32'(fd_cnt), 32'd2);

      // Frame C: one line too many
      frame_start();
      repeat (V + 1) send_line(2 * H);
      chk("ovf_writes", 32'(wr_total), 32'd35);
      chk("ovf_addr", 32'(addr), 32'(H * V - 1));
      chk("ovf_err", 32'(err_line), 32'd1);
      chk("ovf_lines", 32'(line_count), 32'd4);
      frame_end();
      chk("ovf_frame_done", 32'(fd_cnt), 32'd3);
      chk("addr_seq_abc", 32'(addr_err), 32'd0);

      // Frame D: reset between the two bytes of a pixel, then a clean frame
      frame_start();
      send_line(8);
      step(1'b0, 1'b1, 8'h0A);
      step(1'b0, 1'b1, 8'hBC);
      rst = 1'b1;
      #1;
      chk("midrst_we", 32'(we), 32'd0);
      chk("midrst_addr", 32'(addr), 32'd0);
      step(1'b0, 1'b1, 8'h0A);
      step(1'b0, 1'b1, 8'hBC);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, (i % 2 == 1) ? 8'hBC : 8'h0A);
      idle(4);
      send_line(8);
      chk("midrst_no_write", 32'(wr_total), 32'd39);
      frame_start();
      repeat (V) send_line(2 * H);
      chk("post_rst_writes", 32'(wr_total), 32'd51);
      chk("post_rst_addr", 32'(addr), 32'(H * V - 1));
      chk("post_rst_lines", 32'(line_count), 32'd3);
      chk("post_rst_err", 32'(err_line), 32'd0);
      frame_end();
      chk("post_rst_fd", 32'(fd_cnt), 32'd4);
      chk("addr_seq_all", 32'(addr_err), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
